mbist_march_ctrl: RTL
=====================

# mbist_march_ctrl

March C- memory BIST controller. It drives the single-port test memory's `write_read`/`address`/`wdata` bus and compares `rdata` against expected values. It reports pass/fail, the first failing location and a saturating error count to the test-top. It sits between the chip-level BIST start/status registers and the memory under test, replacing functional access during test.

## Interface
- `DATA_WIDTH`, 8, memory word width.
- `ADDR_WIDTH`, 4, memory address width.
- `CAPACITY`, 15, highest valid address; the test covers 0..CAPACITY, so N = CAPACITY+1 words.
- `ERR_W`, 8, error counter width.

Ports:
- `clk` — in, 1 — single clock; all logic is on the rising edge.
- `rst_n` — in, 1 — asynchronous, active-low reset.
- `start` — in, 1 — level-sampled request to begin a test run.
- `bist_busy` — out, 1 — a run is in progress.
- `bist_done` — out, 1 — the run has completed; held until the next accepted start.
- `bist_fail` — out, 1 — at least one miscompare in the last run; held until the next accepted start.
- `fail_addr` — out, ADDR_WIDTH — address of the first miscompare.
- `fail_expect` — out, DATA_WIDTH — expected word at the first miscompare.
- `fail_actual` — out, DATA_WIDTH — read word at the first miscompare.
- `err_cnt` — out, ERR_W — total miscompares, saturating.
- `mem_write_read` — out, 1 — 1 = write, 0 = read.
- `mem_address` — out, ADDR_WIDTH — memory address.
- `mem_wdata` — out, DATA_WIDTH — write data.
- `mem_rdata` — in, DATA_WIDTH — memory read data.

## Operation
- Algorithm (March C-), background B0 = all-zeros word, B1 = all-ones word:
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
- ⇑ runs addresses 0..CAPACITY; ⇓ runs CAPACITY..0. Two-op elements complete both ops on one address before the address steps.
- FSM states: IDLE, SETUP, RUN, DRAIN, DONE.
  - IDLE/DONE → SETUP when `start`=1. On entry, clear `bist_done`, `bist_fail`, `err_cnt`, `fail_*`, and set element = E0.
  - SETUP lasts 1 cycle. `mem_write_read`=0, `mem_address` = the element's first address, `mem_wdata` = the element's write background. The read result is discarded.
  - RUN issues one op per cycle. After the last op of E0–E4 → SETUP of the next element. After the last op of E5 → DRAIN.
  - DRAIN lasts 2 cycles with `mem_write_read`=0; the read result is discarded. Then → DONE.
  - DONE asserts `bist_done`=1 and `bist_busy`=0.
- Write-data skew: the memory captures write data one cycle before the write strobe. `mem_wdata` must therefore carry the current element's write background in SETUP and throughout RUN. Because each element writes only one background, `mem_wdata` is constant per element.
- Compare pipeline: 2 stages, each holding {valid, expected, address}. A RUN read issued in cycle t is compared against `mem_rdata` in cycle t+2. Writes, SETUP reads and DRAIN reads enter the pipeline with valid=0.
- On a valid miscompare:
  - `err_cnt` +1, saturating at 2^ERR_W−1.
  - If `bist_fail`=0, latch `fail_addr`, `fail_expect` and `fail_actual`, then set `bist_fail`=1. Later miscompares do not update the `fail_*` registers.
- `start` is ignored while `bist_busy`=1.

## Timing
- Reset values (asynchronous):
  - State = IDLE.
  - `bist_busy`, `bist_done`, `bist_fail`, `mem_write_read` = 0.
  - `mem_address`, `mem_wdata`, `fail_addr`, `fail_expect`, `fail_actual`, `err_cnt` = 0.
  - Compare pipeline valids = 0.
- `start` sampled at edge k → SETUP in cycle k+1, with `bist_busy`=1 from cycle k+1.
- `bist_busy` stays high for 10N+8 cycles: 6 SETUP cycles + 10N RUN cycles + 2 DRAIN cycles. For N=16 this is 168 cycles.
- `bist_done` rises in the same cycle `bist_busy` falls.
- The last E5 read is compared in DRAIN cycle 2, so status is final when `bist_done` rises.
- Reset mid-run: all outputs return to reset values immediately, with no memory write after reset assertion. A new run needs a fresh `start` after reset is released.
- Boundary cases:
  - Address wrap: ⇑ ends at CAPACITY and ⇓ ends at 0 with no wrap-around op.
  - A counter at saturation holds its value.
  - A miscompare in the same cycle that `start` is re-accepted is impossible, because DONE has no valid compares in flight.

## Test plan
- Fault-free memory, N=16, `start` pulse → `bist_busy` high for exactly 168 cycles, then `bist_done`=1, `bist_fail`=0, `err_cnt`=0.
- Bit 3 stuck-at-0 at address 5 → `bist_fail`=1, `fail_addr`=5, `fail_expect`=8'hFF, `fail_actual`=8'hF7 (first seen in E2), `err_cnt`=2.
- Address-sequence check: monitor `mem_address` during E3 → 15,15,14,14,…,0,0 with `mem_write_read` pattern 0,1 repeating and `mem_wdata`=8'hFF throughout.
- `start` held high for the whole run plus 1 cycle → exactly one run, then a second run begins from DONE. Status clears at the second SETUP.
- `rst_n` asserted at cycle 50 of a run → outputs at reset values in the same cycle. After release with `start` low, the block stays IDLE with no memory writes.
- ERR_W=2, every cell of the memory returns 8'h55 → `err_cnt` saturates at 3, `fail_addr`=0, `fail_expect`=8'h00, `fail_actual`=8'h55.

Source files
------------

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences the six march elements over a
// single-port memory, compares read data two cycles later and logs failures.
module mbist_march_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CAPACITY   = 15,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_expect,
  output logic [DATA_WIDTH-1:0] fail_actual,
  output logic [ERR_W-1:0]      err_cnt,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(CAPACITY);
  localparam logic [ERR_W-1:0]      ERR_MAX   = '1;
  localparam logic [2:0]            ELEM_LAST = 3'd5;

  state_t                state;
  logic [2:0]            elem;
  logic                  phase;
  logic                  drain_cnt;
  logic                  s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0] s1_expect, s2_expect;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;

  logic                  elem_down;
  logic                  two_op;
  logic                  last_op;
  logic                  miscmp;
  logic [2:0]            nxt_elem;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic [DATA_WIDTH-1:0] rd_bg;

  // Write background per element; E5 has no write and keeps all-zeros.
  function automatic logic [DATA_WIDTH-1:0] wr_bg(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? '1 : '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
    return (e == 3'd3 || e == 3'd4) ? ADDR_LAST : '0;
  endfunction

  always_comb begin
    elem_down = (elem == 3'd3) || (elem == 3'd4);
    two_op    = (elem != 3'd0) && (elem != ELEM_LAST);
    end_addr  = elem_down ? '0 : ADDR_LAST;
    last_op   = (mem_address == end_addr) && (!two_op || phase);
    nxt_elem  = elem + 3'd1;
    rd_bg     = (elem == 3'd2 || elem == 3'd4) ? '1 : '0;
    miscmp    = s2_valid && (mem_rdata != s2_expect);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      elem           <= 3'd0;
      phase          <= 1'b0;
      drain_cnt      <= 1'b0;
      s1_valid       <= 1'b0;
      s2_valid       <= 1'b0;
      s1_expect      <= '0;
      s2_expect      <= '0;
      s1_addr        <= '0;
      s2_addr        <= '0;
      bist_busy      <= 1'b0;
      bist_done      <= 1'b0;
      bist_fail      <= 1'b0;
      fail_addr      <= '0;
      fail_expect    <= '0;
      fail_actual    <= '0;
      err_cnt        <= '0;
      mem_write_read <= 1'b0;
      mem_address    <= '0;
      mem_wdata      <= '0;
    end else begin
      // Only RUN reads are compared; everything else travels with valid=0.
      s1_valid  <= (state == S_RUN) && !mem_write_read;
      s1_expect <= rd_bg;
      s1_addr   <= mem_address;
      s2_valid  <= s1_valid;
      s2_expect <= s1_expect;
      s2_addr   <= s1_addr;

      if (miscmp) begin
        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
        if (!bist_fail) begin
          bist_fail   <= 1'b1;
          fail_addr   <= s2_addr;
          fail_expect <= s2_expect;
          fail_actual <= mem_rdata;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_SETUP;
            bist_busy      <= 1'b1;
            bist_done      <= 1'b0;
            bist_fail      <= 1'b0;
            fail_addr      <= '0;
            fail_expect    <= '0;
            fail_actual    <= '0;
            err_cnt        <= '0;
            elem           <= 3'd0;
            phase          <= 1'b0;
            mem_write_read <= 1'b0;
            mem_address    <= first_addr(3'd0);
            mem_wdata      <= wr_bg(3'd0);
          end
        end
        S_SETUP: begin
          state          <= S_RUN;
          phase          <= 1'b0;
          mem_write_read <= (elem == 3'd0);
        end
        S_RUN: begin
          if (last_op) begin
            phase          <= 1'b0;
            mem_write_read <= 1'b0;
            if (elem == ELEM_LAST) begin
              state     <= S_DRAIN;
              drain_cnt <= 1'b0;
            end else begin
              state       <= S_SETUP;
              elem        <= nxt_elem;
              mem_address <= first_addr(nxt_elem);
              mem_wdata   <= wr_bg(nxt_elem);
            end
          end else if (two_op && !phase) begin
            phase          <= 1'b1;
            mem_write_read <= 1'b1;
          end else begin
            phase          <= 1'b0;
            mem_write_read <= (elem == 3'd0);
            mem_address    <= elem_down ? mem_address - ADDR_WIDTH'(1)
                                        : mem_address + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state     <= S_DONE;
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
